cla16_sub_pipe: RTL



---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla16_sub_pipe_if.sv | 26 ++
 rtl/cla4_slice.sv | 20 ++
 rtl/cla16_sub_pipe.sv | 117 +++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared 4-bit carry-look-ahead types and carry function
package cla_pkg;

   localparam int SLICE_W = 4;

   typedef struct packed {
      logic [SLICE_W-1:0] sum;
      logic               cout;
   } slice_res_t;

   // Fully expanded look-ahead: every carry is a two-level function of p, g, c0.
   function automatic logic [SLICE_W:0] cla_carries(
      input logic [SLICE_W-1:0] p,
      input logic [SLICE_W-1:0] g,
      input logic               c0
   );
      logic [SLICE_W:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/cla16_sub_pipe_if.sv
// rtl/cla16_sub_pipe_if.sv - operand/result handshake bundle for the pipelined subtractor
interface cla16_sub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );
endinterface

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-look-ahead adder slice
module cla4_slice
   import cla_pkg::*;
(
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);
   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;

   assign p    = x ^ y;
   assign g    = x & y;
   assign c    = cla_carries(p, g, cin);
   assign s    = p ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];
endmodule

// File: rtl/cla16_sub_pipe.sv
// rtl/cla16_sub_pipe.sv - pipelined CLA subtractor, one 4-bit slice per stage, valid/ready on both sides
module cla16_sub_pipe
   import cla_pkg::*;
#(
   parameter  int WIDTH  = 16,
   localparam int NSLICE = WIDTH / SLICE_W
) (
   input logic             clk,
   input logic             rst_n,
   cla16_sub_pipe_if.slave bus
);
   localparam int NREG = NSLICE - 1;

   logic               adv;
   logic [SLICE_W-1:0] sx [NSLICE];
   logic [SLICE_W-1:0] sy [NSLICE];
   logic               sc [NSLICE];
   slice_res_t         res [NSLICE];
   logic [WIDTH-1:0]   nsum [NSLICE];

   logic [WIDTH-1:0]   x_q [NREG];
   logic [WIDTH-1:0]   y_q [NREG];
   logic [WIDTH-1:0]   s_q [NREG];
   logic               c_q [NREG];
   logic               v_q [NREG];
   logic               am_q [NREG];
   logic               bm_q [NREG];

   logic               out_valid_q;
   logic [WIDTH-1:0]   diff_q;
   logic               bout_q;
   logic               ovf_q;
   logic               zero_q;

   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.diff     = diff_q;
   assign bus.bout     = bout_q;
   assign bus.ovf      = ovf_q;
   assign bus.zero     = zero_q;

   // Subtraction as a + ~b + ~bin; later stages consume operands shifted down so their slice sits at [3:0].
   always_comb begin
      sx[0] = bus.a[SLICE_W-1:0];
      sy[0] = ~bus.b[SLICE_W-1:0];
      sc[0] = ~bus.bin;
      for (int k = 1; k < NSLICE; k++) begin
         sx[k] = x_q[k-1][SLICE_W-1:0];
         sy[k] = y_q[k-1][SLICE_W-1:0];
         sc[k] = c_q[k-1];
      end
   end

   for (genvar k = 0; k < NSLICE; k++) begin : g_slice
      logic [SLICE_W-1:0] s;
      logic               co;
      cla4_slice u_slice (
         .x    (sx[k]),
         .y    (sy[k]),
         .cin  (sc[k]),
         .s    (s),
         .cout (co)
      );
      assign res[k] = '{sum: s, cout: co};
   end

   // Result bits enter at the top and shift down one slice per stage, landing aligned after the last.
   always_comb begin
      nsum[0] = WIDTH'(res[0].sum) << (WIDTH - SLICE_W);
      for (int k = 1; k < NSLICE; k++) begin
         nsum[k] = (s_q[k-1] >> SLICE_W) | (WIDTH'(res[k].sum) << (WIDTH - SLICE_W));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            x_q[k]  <= '0;
            y_q[k]  <= '0;
            s_q[k]  <= '0;
            c_q[k]  <= 1'b0;
            v_q[k]  <= 1'b0;
            am_q[k] <= 1'b0;
            bm_q[k] <= 1'b0;
         end
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (adv) begin
         v_q[0]  <= bus.in_valid;
         x_q[0]  <= bus.a >> SLICE_W;
         y_q[0]  <= (~bus.b) >> SLICE_W;
         s_q[0]  <= nsum[0];
         c_q[0]  <= res[0].cout;
         am_q[0] <= bus.a[WIDTH-1];
         bm_q[0] <= bus.b[WIDTH-1];
         for (int k = 1; k < NREG; k++) begin
            v_q[k]  <= v_q[k-1];
            x_q[k]  <= x_q[k-1] >> SLICE_W;
            y_q[k]  <= y_q[k-1] >> SLICE_W;
            s_q[k]  <= nsum[k];
            c_q[k]  <= res[k].cout;
            am_q[k] <= am_q[k-1];
            bm_q[k] <= bm_q[k-1];
         end
         out_valid_q <= v_q[NREG-1];
         diff_q      <= nsum[NSLICE-1];
         bout_q      <= ~res[NSLICE-1].cout;
         ovf_q       <= (am_q[NREG-1] != bm_q[NREG-1]) &&
                        (nsum[NSLICE-1][WIDTH-1] != am_q[NREG-1]);
         zero_q      <= (nsum[NSLICE-1] == '0);
      end
   end
endmodule
